// File: rtl/exponent_multiplier_ctrl_pkg.sv
// Shared definitions for the exponent_multiplier command controller:
// state encoding, default widths and the default completion timeout.
package em_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_START = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_RESP  = 3'd4;

   localparam int DATA_W_DEF  = 4;
   localparam int RES_W_DEF   = 30;
   localparam int TIMEOUT_DEF = 255;

   // Width that holds every value 0..timeout inclusive.
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/exponent_multiplier_ctrl_if.sv
// Request/response and core-side signals of the controller; slave is the
// controller view, master is the requester plus core view.
interface em_if
   import em_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RES_W  = RES_W_DEF
);

   logic              i_req_valid;
   logic              o_req_ready;
   logic [DATA_W-1:0] i_req_a;
   logic [DATA_W-1:0] i_req_b;
   logic              i_req_sel;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [RES_W-1:0]  o_rsp_data;
   logic              o_rsp_timeout;
   logic              o_load;
   logic              o_start;
   logic              o_select;
   logic [DATA_W-1:0] o_A;
   logic [DATA_W-1:0] o_B;
   logic              i_done;
   logic [RES_W-1:0]  i_P;

   modport slave (
      input  i_req_valid, i_req_a, i_req_b, i_req_sel, i_rsp_ready, i_done, i_P,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_timeout,
             o_load, o_start, o_select, o_A, o_B
   );

   modport master (
      output i_req_valid, i_req_a, i_req_b, i_req_sel, i_rsp_ready, i_done, i_P,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_timeout,
             o_load, o_start, o_select, o_A, o_B
   );

endinterface

// File: rtl/exponent_multiplier_ctrl_timeout_counter.sv
// Saturating cycle counter bounding the wait for core completion; expired
// stays high once the count reaches TIMEOUT until the next clear.
module em_timeout_counter
   import em_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int             CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear has priority; counting stops at LIMIT instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (enable && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/exponent_multiplier_ctrl.sv
// Sequences load/start pulses of the exponent_multiplier core for one
// request at a time and returns the result (or a timeout) on a response port.
module exponent_multiplier_ctrl
   import em_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RES_W   = RES_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic  i_clk,
   input logic  i_rst,
   em_if.slave  bus
);

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] a_d;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] b_d;
   logic              sel_q;
   logic              sel_d;
   logic [RES_W-1:0]  rsp_data_q;
   logic [RES_W-1:0]  rsp_data_d;
   logic              rsp_timeout_q;
   logic              rsp_timeout_d;
   logic              done_q;

   logic accept;
   logic completion;
   logic in_wait;
   logic cnt_clear;
   logic cnt_enable;
   logic cnt_expired;

   assign accept     = bus.i_req_valid & (state_q == ST_IDLE);
   assign in_wait    = (state_q == ST_WAIT);
   // Only a fresh rising edge counts: a done level held over from the
   // previous operation must not complete the new one.
   assign completion = bus.i_done & ~done_q;
   assign cnt_clear  = (state_q == ST_START);
   assign cnt_enable = in_wait & ~completion;

   em_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .expired (cnt_expired)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         a_q           <= {DATA_W{1'b0}};
         b_q           <= {DATA_W{1'b0}};
         sel_q         <= 1'b0;
         rsp_data_q    <= {RES_W{1'b0}};
         rsp_timeout_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         sel_q         <= sel_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         done_q        <= bus.i_done;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD:  state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (completion || cnt_expired) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (bus.i_rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operands hold from accept to accept; the response holds through RESP.
   always_comb begin
      a_d           = a_q;
      b_d           = b_q;
      sel_d         = sel_q;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      if (accept) begin
         a_d   = bus.i_req_a;
         b_d   = bus.i_req_b;
         sel_d = bus.i_req_sel;
      end else begin
         a_d   = a_q;
         b_d   = b_q;
         sel_d = sel_q;
      end
      // Completion is tested first so it wins over a same-cycle timeout.
      if (in_wait && completion) begin
         rsp_data_d    = bus.i_P;
         rsp_timeout_d = 1'b0;
      end else if (in_wait && cnt_expired) begin
         rsp_data_d    = {RES_W{1'b0}};
         rsp_timeout_d = 1'b1;
      end else begin
         rsp_data_d    = rsp_data_q;
         rsp_timeout_d = rsp_timeout_q;
      end
   end

   always_comb begin
      bus.o_req_ready = 1'b0;
      bus.o_load      = 1'b0;
      bus.o_start     = 1'b0;
      bus.o_rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE:  bus.o_req_ready = 1'b1;
         ST_LOAD:  bus.o_load      = 1'b1;
         ST_START: bus.o_start     = 1'b1;
         ST_RESP:  bus.o_rsp_valid = 1'b1;
         default: begin
            bus.o_req_ready = 1'b0;
            bus.o_rsp_valid = 1'b0;
         end
      endcase
      bus.o_A           = a_q;
      bus.o_B           = b_q;
      bus.o_select      = sel_q;
      bus.o_rsp_data    = rsp_data_q;
      bus.o_rsp_timeout = rsp_timeout_q;
   end

endmodule

// File: tb/tb_exponent_multiplier_ctrl.sv
// Bench for exponent_multiplier_ctrl with a behavioural core model (A*B or
// A^B, done level a fixed number of cycles after start).
module tb_exponent_multiplier_ctrl;

   localparam int TO   = 8;
   localparam int MAXC = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec = 0;
   int   err = 0;

   always #5 clk = ~clk;

   em_if #(.DATA_W(4), .RES_W(30)) bus ();

   exponent_multiplier_ctrl #(.DATA_W(4), .RES_W(30), .TIMEOUT(TO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   function automatic logic [29:0] ref_result(input logic [3:0] a, input logic [3:0] b,
                                              input logic sel);
      longint p;
      p = 64'sd1;
      if (sel) begin
         for (int i = 0; i < int'(b); i++) p = p * longint'(a);
      end else begin
         p = longint'(a) * longint'(b);
      end
      return p[29:0];
   endfunction

   // Core model: done rises done_delay cycles after the start cycle and stays
   // high until the next start; stale_hold extends an old level past start.
   int          ssc        = 1000;
   bit          started    = 1'b0;
   bit          prev_done  = 1'b0;
   bit          never_done = 1'b0;
   int          done_delay = 5;
   int          stale_hold = 0;
   logic [29:0] res_q      = 30'd0;
   logic [29:0] junk_q     = 30'd0;

   always @(posedge clk) begin
      if (rst) begin
         started <= 1'b0;
         ssc     <= 1000;
      end else if (bus.o_start) begin
         started   <= 1'b1;
         ssc       <= 1;
         prev_done <= bus.i_done;
         res_q     <= ref_result(bus.o_A, bus.o_B, bus.o_select);
         junk_q    <= 30'($urandom());
      end else if (ssc < 1000) begin
         ssc <= ssc + 1;
      end
   end

   assign bus.i_done = started && !never_done &&
                       ((ssc >= done_delay) || (prev_done && (ssc <= stale_hold)));
   assign bus.i_P    = bus.i_done ? res_q : junk_q;

   // Drives one request in the current cycle (T) and records, relative to T,
   // when load/start/response are seen; returns in the first response cycle.
   task automatic send_req(input logic [3:0] a, input logic [3:0] b, input logic sel,
                           output int t_load, output int t_start, output int t_rsp,
                           output logic [29:0] data, output logic to,
                           output int n_load, output int n_start);
      bus.i_req_a     = a;
      bus.i_req_b     = b;
      bus.i_req_sel   = sel;
      bus.i_req_valid = 1'b1;
      t_load = -1; t_start = -1; t_rsp = -1; n_load = 0; n_start = 0;
      data = 30'd0; to = 1'b0;
      for (int k = 1; k <= MAXC; k++) begin
         @(negedge clk);
         if (k == 1) bus.i_req_valid = 1'b0;
         if (bus.o_load)  begin n_load++;  if (t_load  < 0) t_load  = k; end
         if (bus.o_start) begin n_start++; if (t_start < 0) t_start = k; end
         if (bus.o_rsp_valid) begin
            t_rsp = k; data = bus.o_rsp_data; to = bus.o_rsp_timeout;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.i_req_valid = 1'b0; bus.i_rsp_ready = 1'b1;
      bus.i_req_a = 4'd0; bus.i_req_b = 4'd0; bus.i_req_sel = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vec++; if (bus.o_req_ready !== 1'b1) begin err++; $display("FAIL reset_ready: got %0b expected 1", bus.o_req_ready); end
      vec++; if (bus.o_load !== 1'b0) begin err++; $display("FAIL reset_load: got %0b expected 0", bus.o_load); end
      vec++; if (bus.o_start !== 1'b0) begin err++; $display("FAIL reset_start: got %0b expected 0", bus.o_start); end
      vec++; if (bus.o_select !== 1'b0) begin err++; $display("FAIL reset_select: got %0b expected 0", bus.o_select); end
      vec++; if (bus.o_rsp_valid !== 1'b0) begin err++; $display("FAIL reset_rsp_valid: got %0b expected 0", bus.o_rsp_valid); end
      vec++; if (bus.o_rsp_timeout !== 1'b0) begin err++; $display("FAIL reset_timeout: got %0b expected 0", bus.o_rsp_timeout); end
      vec++; if ({bus.o_A, bus.o_B} !== 8'd0) begin err++; $display("FAIL reset_operands: got %h expected 00", {bus.o_A, bus.o_B}); end
      vec++; if (bus.o_rsp_data !== 30'd0) begin err++; $display("FAIL reset_data: got %0d expected 0", bus.o_rsp_data); end
   endtask

   task automatic test_min_latency();
      int t_l, t_s, t_r, n_l, n_s; logic [29:0] d; logic to; logic [3:0] a, b; logic s;
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); s = 1'($urandom());
      done_delay = 1;
      send_req(a, b, s, t_l, t_s, t_r, d, to, n_l, n_s);
      vec++; if (t_r !== 4) begin err++; $display("FAIL min_latency: got %0d expected 4", t_r); end
      vec++; if (d !== ref_result(a, b, s)) begin err++; $display("FAIL min_data: got %0d expected %0d", d, ref_result(a, b, s)); end
      @(negedge clk);
      done_delay = 5;
   endtask

   task automatic test_mult();
      int t_l, t_s, t_r, n_l, n_s; logic [29:0] d; logic to;
      vec++; if (bus.o_req_ready !== 1'b1) begin err++; $display("FAIL mult_ready: got %0b expected 1", bus.o_req_ready); end
      send_req(4'd6, 4'd2, 1'b0, t_l, t_s, t_r, d, to, n_l, n_s);
      vec++; if (t_l !== 1) begin err++; $display("FAIL mult_load_time: got %0d expected 1", t_l); end
      vec++; if (t_s !== 2) begin err++; $display("FAIL mult_start_time: got %0d expected 2", t_s); end
      vec++; if (n_l !== 1 || n_s !== 1) begin err++; $display("FAIL mult_pulse_count: got %0d/%0d expected 1/1", n_l, n_s); end
      vec++; if (t_r !== 3 + done_delay) begin err++; $display("FAIL mult_rsp_time: got %0d expected %0d", t_r, 3 + done_delay); end
      vec++; if (d !== 30'd12) begin err++; $display("FAIL mult_data: got %0d expected 12", d); end
      vec++; if (to !== 1'b0) begin err++; $display("FAIL mult_timeout: got %0b expected 0", to); end
      @(negedge clk);
   endtask

   task automatic test_exp();
      int t_l, t_s, t_r, n_l, n_s; logic [29:0] d; logic to;
      send_req(4'd2, 4'd10, 1'b1, t_l, t_s, t_r, d, to, n_l, n_s);
      vec++; if (d !== 30'd1024) begin err++; $display("FAIL exp_data: got %0d expected 1024", d); end
      vec++; if (to !== 1'b0) begin err++; $display("FAIL exp_timeout: got %0b expected 0", to); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++; if (bus.o_select !== 1'b1 || bus.o_A !== 4'd2 || bus.o_B !== 4'd10) begin
            err++; $display("FAIL exp_hold: got sel=%0b A=%0d B=%0d expected 1/2/10", bus.o_select, bus.o_A, bus.o_B);
         end
      end
   endtask

   task automatic test_stale_done();
      int t_l, t_s, t_r, n_l, n_s; logic [29:0] d; logic to; logic [3:0] a, b; logic s;
      a = 4'($urandom_range(1, 15)); b = 4'($urandom_range(0, 15)); s = 1'($urandom());
      stale_hold = 2;
      send_req(a, b, s, t_l, t_s, t_r, d, to, n_l, n_s);
      vec++; if (t_r !== 3 + done_delay) begin err++; $display("FAIL stale_rsp_time: got %0d expected %0d", t_r, 3 + done_delay); end
      vec++; if (d !== ref_result(a, b, s)) begin err++; $display("FAIL stale_data: got %0d expected %0d", d, ref_result(a, b, s)); end
      @(negedge clk);
      stale_hold = 0;
   endtask

   task automatic test_timeout();
      int t_l, t_s, t_r, n_l, n_s; logic [29:0] d; logic to;
      never_done = 1'b1;
      send_req(4'($urandom()), 4'($urandom()), 1'($urandom()), t_l, t_s, t_r, d, to, n_l, n_s);
      vec++; if (t_r !== 3 + TO + 1) begin err++; $display("FAIL timeout_rsp_time: got %0d expected %0d", t_r, 3 + TO + 1); end
      vec++; if (to !== 1'b1) begin err++; $display("FAIL timeout_flag: got %0b expected 1", to); end
      vec++; if (d !== 30'd0) begin err++; $display("FAIL timeout_data: got %0d expected 0", d); end
      @(negedge clk);
      never_done = 1'b0;
   endtask

   task automatic test_backpressure();
      int t_l, t_s, t_r, n_l, n_s; logic [29:0] d; logic to; logic [3:0] a, b; logic s;
      a = 4'($urandom()); b = 4'($urandom()); s = 1'($urandom());
      bus.i_rsp_ready = 1'b0;
      send_req(a, b, s, t_l, t_s, t_r, d, to, n_l, n_s);
      vec++; if (d !== ref_result(a, b, s) || t_r !== 3 + done_delay) begin
         err++; $display("FAIL bp_first: got %0d@%0d expected %0d@%0d", d, t_r, ref_result(a, b, s), 3 + done_delay);
      end
      bus.i_req_valid = 1'b1; bus.i_req_a = ~a; bus.i_req_b = ~b;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vec++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== ref_result(a, b, s) ||
                    bus.o_rsp_timeout !== 1'b0 || bus.o_req_ready !== 1'b0 || bus.o_load !== 1'b0) begin
            err++; $display("FAIL bp_hold: got v=%0b d=%0d to=%0b rdy=%0b ld=%0b expected 1/%0d/0/0/0",
                            bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_timeout, bus.o_req_ready, bus.o_load, ref_result(a, b, s));
         end
      end
      bus.i_req_valid = 1'b0; bus.i_rsp_ready = 1'b1;
      @(negedge clk);
      vec++; if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
         err++; $display("FAIL bp_release: got v=%0b rdy=%0b expected 0/1", bus.o_rsp_valid, bus.o_req_ready);
      end
      send_req(a, b, s, t_l, t_s, t_r, d, to, n_l, n_s);
      vec++; if (t_l !== 1) begin err++; $display("FAIL bp_next_accept: got %0d expected 1", t_l); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int t_l, t_s, t_r, n_l, n_s; logic [29:0] d; logic to; logic [3:0] a, b; logic s;
      for (int i = 0; i < 4; i++) begin
         a = 4'($urandom()); b = 4'($urandom()); s = 1'($urandom());
         vec++; if (bus.o_req_ready !== 1'b1) begin err++; $display("FAIL b2b_ready: got %0b expected 1", bus.o_req_ready); end
         send_req(a, b, s, t_l, t_s, t_r, d, to, n_l, n_s);
         vec++; if (t_r !== 3 + done_delay || d !== ref_result(a, b, s)) begin
            err++; $display("FAIL b2b_rsp: got %0d@%0d expected %0d@%0d", d, t_r, ref_result(a, b, s), 3 + done_delay);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_wait();
      int bad;
      bus.i_req_a = 4'd5; bus.i_req_b = 4'd3; bus.i_req_sel = 1'b1; bus.i_req_valid = 1'b1;
      @(negedge clk);
      bus.i_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vec++; if (bus.o_req_ready !== 1'b1) begin err++; $display("FAIL rmw_ready: got %0b expected 1", bus.o_req_ready); end
      vec++; if ({bus.o_load, bus.o_start, bus.o_select, bus.o_rsp_valid, bus.o_rsp_timeout} !== 5'd0) begin
         err++; $display("FAIL rmw_ctrl: got %b expected 00000", {bus.o_load, bus.o_start, bus.o_select, bus.o_rsp_valid, bus.o_rsp_timeout});
      end
      vec++; if ({bus.o_A, bus.o_B} !== 8'd0 || bus.o_rsp_data !== 30'd0) begin
         err++; $display("FAIL rmw_data: got A=%0d B=%0d d=%0d expected 0", bus.o_A, bus.o_B, bus.o_rsp_data);
      end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.o_rsp_valid || bus.o_load || bus.o_start) bad++;
      end
      vec++; if (bad !== 0) begin err++; $display("FAIL rmw_no_rsp: got %0d active cycles expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_min_latency();
      test_mult();
      test_exp();
      test_stale_done();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
